// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronizes and debounces both chutes, turns rising
// edges into one-cycle coin codes, refuses ambiguous or locked-out insertions, flags jams.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned JAM_CYCLES      = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       coin05_raw,
  input  logic       coin10_raw,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam
);

  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  LOCK_LD  = 8'(LOCKOUT_CYCLES);
  localparam logic [15:0] JAM_LIM  = 16'(JAM_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_JAM} state_t;

  // Channel index 0 is the 0.5 chute, index 1 is the 1.0 chute.
  logic [1:0]  meta_q, sync_q, filt_q, filt_d, fprev_q;
  logic [7:0]  dcnt_q [2];
  logic [7:0]  dcnt_d [2];
  logic [15:0] hcnt_q [2];
  logic [15:0] hcnt_d [2];
  logic [1:0]  ev;
  logic        jam_hit;

  state_t      state_q, state_d;
  logic [7:0]  lcnt_q, lcnt_d;
  logic [1:0]  coin_q, coin_d;
  logic        reject_q, reject_d;
  logic        jam_q, jam_d;

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = '0;
      hcnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) filt_d[i] = sync_q[i];
        else                       dcnt_d[i] = dcnt_q[i] + 8'd1;
      end
      if (filt_q[i]) hcnt_d[i] = (hcnt_q[i] == JAM_LIM) ? hcnt_q[i] : hcnt_q[i] + 16'd1;
    end
  end

  assign ev = filt_q & ~fprev_q;
  // Saturated count only matters while the level is still high, so release exits JAM at once.
  assign jam_hit = (filt_q[0] && (hcnt_q[0] == JAM_LIM)) ||
                   (filt_q[1] && (hcnt_q[1] == JAM_LIM));

  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    coin_d   = 2'b00;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev != 2'b00) begin
          // An event channel is high, so both high means simultaneous or overlapping coins.
          if (filt_q == 2'b11) begin
            reject_d = 1'b1;
          end else begin
            coin_d  = ev;
            state_d = S_LOCK;
            lcnt_d  = LOCK_LD;
          end
        end
      end
      S_LOCK: begin
        lcnt_d = lcnt_q - 8'd1;
        if (lcnt_q <= 8'd1) begin
          lcnt_d  = '0;
          state_d = S_IDLE;
        end
        if (ev != 2'b00) reject_d = 1'b1;
      end
      S_JAM: begin
        if (filt_q == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (jam_hit) begin
      state_d  = S_JAM;
      coin_d   = 2'b00;
      reject_d = 1'b0;
    end
    jam_d = (state_d == S_JAM);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q   <= '0;
      sync_q   <= '0;
      filt_q   <= '0;
      fprev_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
      state_q  <= S_IDLE;
      lcnt_q   <= '0;
      coin_q   <= '0;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      meta_q   <= {coin10_raw, coin05_raw};
      sync_q   <= meta_q;
      filt_q   <= filt_d;
      fprev_q  <= filt_q;
      dcnt_q   <= dcnt_d;
      hcnt_q   <= hcnt_d;
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      jam_q    <= jam_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;
  assign jam    = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: expected coin/reject pulses and jam edges are
// queued with their cycle when stimulus is applied and matched as the DUT emits them.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       coin05_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic [1:0] coin;
  logic       reject;
  logic       jam;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int cyc; logic [1:0] coin; logic rej;} out_t;
  typedef struct {int cyc; logic lvl;} jev_t;
  out_t sb[$];
  jev_t jq[$];
  out_t e;
  jev_t je;
  logic jam_prev = 1'b0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8),
    .JAM_CYCLES     (64)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .coin05_raw(coin05_raw),
    .coin10_raw(coin10_raw),
    .coin      (coin),
    .reject    (reject),
    .jam       (jam)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: every pulse and every jam edge must match the head of its queue.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (coin !== 2'b00 || reject !== 1'b0) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_output: coin=%b reject=%b at cycle %0d, expected none", coin, reject, cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("coin_code", {30'd0, coin}, {30'd0, e.coin});
          chk("reject", {31'd0, reject}, {31'd0, e.rej});
          chk("out_cycle", cyc, e.cyc);
        end
      end
      if (jam !== jam_prev) begin
        n_cmp++;
        assert (jq.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_jam_edge: jam=%b at cycle %0d, expected no change", jam, cyc);
        end
        if (jq.size() != 0) begin
          je = jq.pop_front();
          chk("jam_level", {31'd0, jam}, {31'd0, je.lvl});
          chk("jam_cycle", cyc, je.cyc);
        end
      end
      jam_prev = jam;
    end
  end

  initial begin
    int m;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_coin", {30'd0, coin}, 32'd0);
    chk("rst_reject", {31'd0, reject}, 32'd0);
    chk("rst_jam", {31'd0, jam}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single 0.5 coin
    m = cyc;
    coin05_raw = 1'b1;
    sb.push_back('{m + 7, 2'b01, 1'b0});
    repeat (10) @(negedge clk);
    coin05_raw = 1'b0;
    repeat (30) @(negedge clk);

    // Three-cycle glitch, then a clean 1.0 coin
    coin10_raw = 1'b1;
    repeat (3) @(negedge clk);
    coin10_raw = 1'b0;
    repeat (15) @(negedge clk);
    m = cyc;
    coin10_raw = 1'b1;
    sb.push_back('{m + 7, 2'b10, 1'b0});
    repeat (10) @(negedge clk);
    coin10_raw = 1'b0;
    repeat (30) @(negedge clk);

    // Simultaneous insertion
    m = cyc;
    coin05_raw = 1'b1;
    coin10_raw = 1'b1;
    sb.push_back('{m + 7, 2'b00, 1'b1});
    repeat (10) @(negedge clk);
    coin05_raw = 1'b0;
    coin10_raw = 1'b0;
    repeat (30) @(negedge clk);

    // Lockout: 1.0 event 3 cycles after the coin, then a 0.5 exactly 9 cycles after
    m = cyc;
    coin05_raw = 1'b1;
    sb.push_back('{m + 7, 2'b01, 1'b0});
    repeat (4) @(negedge clk);
    coin10_raw = 1'b1;
    sb.push_back('{m + 11, 2'b00, 1'b1});
    @(negedge clk);
    coin05_raw = 1'b0;
    repeat (3) @(negedge clk);
    coin10_raw = 1'b0;
    @(negedge clk);
    coin05_raw = 1'b1;
    sb.push_back('{m + 16, 2'b01, 1'b0});
    repeat (5) @(negedge clk);
    coin05_raw = 1'b0;
    repeat (30) @(negedge clk);

    // Jam: 0.5 chute held for 100 cycles with a 1.0 pulse inside the jam
    m = cyc;
    coin05_raw = 1'b1;
    sb.push_back('{m + 7, 2'b01, 1'b0});
    jq.push_back('{m + 71, 1'b1});
    repeat (80) @(negedge clk);
    coin10_raw = 1'b1;
    repeat (10) @(negedge clk);
    coin10_raw = 1'b0;
    repeat (10) @(negedge clk);
    coin05_raw = 1'b0;
    jq.push_back('{m + 107, 1'b0});
    repeat (30) @(negedge clk);

    // Reset while the coin pulse is out, LOCK entered and the 1.0 debounce counting
    m = cyc;
    coin05_raw = 1'b1;
    repeat (4) @(negedge clk);
    coin10_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_coin", {30'd0, coin}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_reset_coin", {30'd0, coin}, 32'd0);
    chk("mid_reset_reject", {31'd0, reject}, 32'd0);
    chk("mid_reset_jam", {31'd0, jam}, 32'd0);
    @(negedge clk);
    coin10_raw = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m = cyc;
    sb.push_back('{m + 7, 2'b01, 1'b0});
    repeat (12) @(negedge clk);
    coin05_raw = 1'b0;
    repeat (30) @(negedge clk);

    chk("pending_outputs", sb.size(), 32'd0);
    chk("pending_jam_edges", jq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end conditioning stage for the vending controller. It converts the two raw coin-sensor levels (0.5-unit and 1-unit chutes) into clean single-cycle coin codes on the 2-bit `coin` bus consumed directly by the vending FSM. It synchronizes and debounces each sensor, rejects ambiguous insertions, enforces a post-coin lockout, and flags jammed chutes.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples needed before a filtered level changes; legal range 2..255.
- `LOCKOUT_CYCLES`, default 8: cycles after an accepted coin during which new insertions are refused; legal range 1..255.
- `JAM_CYCLES`, default 64: cycles a filtered sensor may stay high before a jam is declared; legal range 2..65535, must exceed `DEBOUNCE_CYCLES`.
- `clk`  in  1  system clock; one clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `coin05_raw`  in  1  asynchronous sensor level for the 0.5-unit chute; high while a coin passes.
- `coin10_raw`  in  1  asynchronous sensor level for the 1-unit chute; high while a coin passes.
- `coin`  out  2  coin code to the vending FSM: 2'b01 is 0.5, 2'b10 is 1.0, 2'b00 is none, 2'b11 is never driven. Each code is a one-cycle pulse.
- `reject`  out  1  one-cycle pulse when an insertion is refused.
- `jam`  out  1  level; a chute is jammed.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer (`s05`, `s10`).
- **Debounce:** each channel has a filtered level `f` and a counter.
  - When the synced value differs from `f`, the counter increments. On the cycle it reaches `DEBOUNCE_CYCLES`, `f` takes the synced value and the counter clears.
  - When the synced value equals `f`, the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples never changes `f`.
- **Events:** a rising edge of `f05` or `f10` is an insertion event (`e05`, `e10`). Falling edges carry no event.
- **Control FSM:**
  - **IDLE**
    - A single event, with the other filtered level low, gives `coin` = that code next cycle, then LOCK.
    - Events on both channels in the same cycle give one `reject` pulse, then IDLE.
    - An event while the other filtered level is high gives `reject`, then IDLE.
  - **LOCK**
    - The counter loads `LOCKOUT_CYCLES` on entry and decrements each cycle.
    - Any event in LOCK gives a `reject` pulse, with no coin and no counter reload.
    - The FSM returns to IDLE on the cycle after the counter reaches 0.
  - **JAM**
    - Entered from any state when either filtered level has been continuously high for `JAM_CYCLES` (per-channel high-time counter, saturating).
    - `jam` = 1 while in JAM. Events are ignored silently: no coin, no reject.
    - The FSM exits to IDLE when both filtered levels have been low for one cycle.
- **Precedence in one cycle:** jam entry > reject > accept. A coin already emitted is never retracted.
- **Outputs:** `coin` and `reject` are mutually exclusive in any cycle.
- **Reset:** asynchronous reset mid-operation clears everything immediately.
  - Synchronizers, filtered levels and all counters go to 0.
  - The FSM goes to IDLE.
  - `coin` = 2'b00, `reject` = 0, `jam` = 0.
  - A sensor already high at reset release is debounced normally and produces one event.

## Timing
- All outputs are registered; no combinational path from raw inputs to outputs.
- **Accept latency:** raw level stable high from before rising edge k gives `coin` valid for exactly the cycle following edge k+2+`DEBOUNCE_CYCLES`. That is 6 edges at default.
- **Reject latency:** identical to accept latency.
- **Minimum accepted coin spacing:** `LOCKOUT_CYCLES`+1 cycles between `coin` pulses.
- **Jam timing:** `jam` rises `JAM_CYCLES`+1 cycles after `f` rises. It falls one cycle after both `f` are low, where `f` falls `DEBOUNCE_CYCLES` samples after the raw level falls.

## Test plan
- **Single 0.5 coin.** Stimulus: `coin05_raw` high for 10 cycles at defaults. Required: `coin` = 2'b01 for exactly 1 cycle, 6 edges after the first sampling edge; `reject` = 0; `jam` = 0.
- **Glitch and single 1.0 coin.** Stimulus: `coin10_raw` pulse of 3 cycles, then later a clean 10-cycle pulse. Required: no output for the glitch; then `coin` = 2'b10 exactly once.
- **Simultaneous insertion.** Stimulus: both raw inputs rise on the same edge for 10 cycles. Required: one `reject` pulse; `coin` stays 2'b00.
- **Lockout.** Stimulus: 0.5 coin, then a 1.0 coin whose event lands 3 cycles after the first `coin` pulse. Required: `coin` = 2'b01 once, then a `reject` pulse. A third coin arriving after 9 cycles is accepted.
- **Jam.** Stimulus: `coin05_raw` held high for 100 cycles at defaults, then released; a `coin10_raw` pulse is applied during the jam. Required: one `coin` = 2'b01; `jam` rises 65 cycles after `f05` rises; the 1.0 pulse is silently ignored; `jam` clears after release plus debounce.
- **Reset mid-operation.** Stimulus: assert `rstn` = 0 during LOCK with a debounce count in flight. Required: all outputs 0 immediately. After release, a raw input still high yields exactly one `coin` after full latency.
